alarm_mode_controller: RTL and testbench

Mode and edit controller for the alarm clock. It turns single-cycle button pulses into the UI state (`state`, `h_ptr`, `v_ptr`) consumed by the display data generator. It also owns the four alarm registers and activation bits, and issues load pulses that edit the live time in the timekeeper. It sits between the button debouncers and the timekeeper/display path, and returns to normal mode after a period of inactivity.

---
 rtl/alarm_mode_controller_pkg.sv | 34 +++
 rtl/alarm_mode_controller_bcd_digit_stepper.sv | 48 ++++
 rtl/alarm_mode_controller.sv | 161 ++++++++++++++++
 tb/tb_alarm_mode_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_mode_controller_pkg.sv
// Shared types and digit helpers for the alarm clock mode/edit controller.
// Digit positions index BCD nibbles of a 24-bit HH:MM:SS word, seconds units first.
package alarm_mode_controller_pkg;

    typedef enum logic [1:0] {
        normal_state        = 2'd0,
        time_setting_state  = 2'd1,
        alarm_setting_state = 2'd2
    } state_t;

    localparam logic [2:0] SEC_U  = 3'd0;
    localparam logic [2:0] SEC_T  = 3'd1;
    localparam logic [2:0] MIN_U  = 3'd2;
    localparam logic [2:0] MIN_T  = 3'd3;
    localparam logic [2:0] HOUR_U = 3'd4;
    localparam logic [2:0] HOUR_T = 3'd5;

    localparam int NUM_DIGITS = 6;
    localparam int NUM_ALARMS = 4;

    // Largest legal value of a digit; hours units depends on the current hours tens.
    function automatic logic [3:0] digit_max(input logic [2:0] pos, input logic [3:0] hour_tens);
        logic [3:0] lim;
        case (pos)
            SEC_U, MIN_U: lim = 4'd9;
            SEC_T, MIN_T: lim = 4'd5;
            HOUR_U:       lim = (hour_tens == 4'd2) ? 4'd3 : 4'd9;
            HOUR_T:       lim = 4'd2;
            default:      lim = 4'd9;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/alarm_mode_controller_bcd_digit_stepper.sv
// Combinational +1/-1 step of one BCD digit of an HH:MM:SS word, wrapping inside the
// digit's range and clamping hours units to 3 whenever the result has hours tens of 2.
module bcd_digit_stepper
    import alarm_mode_controller_pkg::*;
(
    input  logic [23:0] word_i,
    input  logic [2:0]  pos_i,
    input  logic        dir_i,
    output logic [23:0] word_o
);

    logic [3:0]  digit;
    logic [3:0]  lim;
    logic [3:0]  stepped;
    logic [23:0] word_w;

    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pos_i == 3'(i)) begin
                digit = word_i[4*i +: 4];
            end
        end

        lim = digit_max(pos_i, word_i[23:20]);

        // An out-of-range digit steps down to the limit rather than to a still-illegal value.
        if (dir_i) begin
            stepped = (digit >= lim) ? 4'd0 : digit + 4'd1;
        end else begin
            stepped = (digit == 4'd0 || digit > lim) ? lim : digit - 4'd1;
        end

        word_w = word_i;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pos_i == 3'(i)) begin
                word_w[4*i +: 4] = stepped;
            end
        end

        if (word_w[23:20] == 4'd2 && word_w[19:16] > 4'd3) begin
            word_w[19:16] = 4'd3;
        end

        word_o = word_w;
    end

endmodule

// File: rtl/alarm_mode_controller.sv
// UI mode/edit controller: turns button pulses into mode, digit/alarm pointers, alarm
// registers and time load strobes; all outputs registered, one cycle after the pulse.
module alarm_mode_controller
    import alarm_mode_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_toggle,
    input  logic [23:0] time_data,
    output state_t      state,
    output logic [2:0]  h_ptr,
    output logic [1:0]  v_ptr,
    output logic [95:0] alarm_data,
    output logic [3:0]  is_activated,
    output logic        time_hold,
    output logic        time_load,
    output logic [23:0] time_load_data
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [2:0]                 h_ptr_q, h_ptr_d;
    logic [1:0]                 v_ptr_q, v_ptr_d;
    logic [NUM_ALARMS-1:0][23:0] alarm_q, alarm_d;
    logic [3:0]                 act_q, act_d;
    logic                       time_hold_q, time_hold_d;
    logic                       time_load_q, time_load_d;
    logic [23:0]                tld_q, tld_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic        any_btn;
    logic [23:0] step_src;
    logic [23:0] step_word;

    assign any_btn  = btn_mode | btn_toggle | btn_left | btn_right | btn_up | btn_down;
    assign step_src = (state_q == time_setting_state) ? time_data : alarm_q[v_ptr_q];

    bcd_digit_stepper u_stepper (
        .word_i (step_src),
        .pos_i  (h_ptr_q),
        .dir_i  (btn_up),
        .word_o (step_word)
    );

    always_comb begin
        state_d     = state_q;
        h_ptr_d     = h_ptr_q;
        v_ptr_d     = v_ptr_q;
        alarm_d     = alarm_q;
        act_d       = act_q;
        tld_d       = tld_q;
        time_load_d = 1'b0;
        cnt_d       = cnt_q;

        // Strict priority on raw pulses: a higher pulse masks lower ones even if it has no effect.
        if (btn_mode) begin
            h_ptr_d = SEC_U;
            case (state_q)
                normal_state: begin
                    state_d = time_setting_state;
                    v_ptr_d = 2'd0;
                end
                time_setting_state: begin
                    state_d = alarm_setting_state;
                    v_ptr_d = 2'd0;
                end
                alarm_setting_state: begin
                    if (v_ptr_q == 2'd3) begin
                        state_d = normal_state;
                        v_ptr_d = 2'd0;
                    end else begin
                        v_ptr_d = v_ptr_q + 2'd1;
                    end
                end
                default: begin
                    state_d = normal_state;
                    v_ptr_d = 2'd0;
                end
            endcase
        end else if (btn_toggle) begin
            if (state_q == alarm_setting_state) begin
                act_d[v_ptr_q] = ~act_q[v_ptr_q];
            end
        end else if (btn_left || btn_right) begin
            if (state_q != normal_state) begin
                if (btn_left) begin
                    h_ptr_d = (h_ptr_q == HOUR_T) ? SEC_U : h_ptr_q + 3'd1;
                end else begin
                    h_ptr_d = (h_ptr_q == SEC_U) ? HOUR_T : h_ptr_q - 3'd1;
                end
            end
        end else if (btn_up || btn_down) begin
            if (state_q == time_setting_state) begin
                tld_d       = step_word;
                time_load_d = 1'b1;
            end else if (state_q == alarm_setting_state) begin
                alarm_d[v_ptr_q] = step_word;
            end
        end

        // Timeout only fires on a quiet cycle, so it never collides with a button action.
        if (state_q == normal_state || any_btn) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d = normal_state;
            h_ptr_d = SEC_U;
            v_ptr_d = 2'd0;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        time_hold_d = (state_d == time_setting_state);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= normal_state;
            h_ptr_q     <= '0;
            v_ptr_q     <= '0;
            alarm_q     <= '0;
            act_q       <= '0;
            time_hold_q <= 1'b0;
            time_load_q <= 1'b0;
            tld_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            h_ptr_q     <= h_ptr_d;
            v_ptr_q     <= v_ptr_d;
            alarm_q     <= alarm_d;
            act_q       <= act_d;
            time_hold_q <= time_hold_d;
            time_load_q <= time_load_d;
            tld_q       <= tld_d;
            cnt_q       <= cnt_d;
        end
    end

    assign state          = state_q;
    assign h_ptr          = h_ptr_q;
    assign v_ptr          = v_ptr_q;
    assign alarm_data     = alarm_q;
    assign is_activated   = act_q;
    assign time_hold      = time_hold_q;
    assign time_load      = time_load_q;
    assign time_load_data = tld_q;

    a_h_ptr_range: assert property (@(posedge clock) disable iff (reset) h_ptr_q <= HOUR_T);
    a_load_in_hold: assert property (@(posedge clock) disable iff (reset) time_load_q |-> time_hold_q);

endmodule

// File: tb/tb_alarm_mode_controller.sv
// Scoreboard bench: driver pushes reference-model expectations, negedge monitor compares.
module tb_alarm_mode_controller;
    import alarm_mode_controller_pkg::*;

    localparam int T = 8;
    localparam logic [5:0] B_NONE  = 6'b000000;
    localparam logic [5:0] B_MODE  = 6'b100000;
    localparam logic [5:0] B_TOG   = 6'b010000;
    localparam logic [5:0] B_LEFT  = 6'b001000;
    localparam logic [5:0] B_RIGHT = 6'b000100;
    localparam logic [5:0] B_UP    = 6'b000010;
    localparam logic [5:0] B_DOWN  = 6'b000001;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        btn_mode = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_toggle = 1'b0;
    logic [23:0] time_data = 24'h0;
    state_t      state;
    logic [2:0]  h_ptr;
    logic [1:0]  v_ptr;
    logic [95:0] alarm_data;
    logic [3:0]  is_activated;
    logic        time_hold, time_load;
    logic [23:0] time_load_data;

    alarm_mode_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset),
        .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down), .btn_toggle(btn_toggle),
        .time_data(time_data),
        .state(state), .h_ptr(h_ptr), .v_ptr(v_ptr),
        .alarm_data(alarm_data), .is_activated(is_activated),
        .time_hold(time_hold), .time_load(time_load), .time_load_data(time_load_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        state_t      st;
        int          h;
        int          v;
        logic [95:0] al;
        logic [3:0]  act;
        bit          hold;
        bit          tl;
        logic [23:0] tld;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0=normal, 1=time setting, 2=alarm setting.
    int          m_mode, m_h, m_v, m_cnt;
    logic [23:0] m_al[4];
    bit          m_act[4];
    bit          m_tl;
    logic [23:0] m_tld;

    task automatic chk(input string nm, input logic [95:0] a, input logic [95:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic state_t mode_to_state(input int m);
        if (m == 1) return time_setting_state;
        if (m == 2) return alarm_setting_state;
        return normal_state;
    endfunction

    function automatic logic [23:0] model_step(input logic [23:0] w, input int pos, input bit up);
        int dg[6];
        int lim;
        logic [23:0] r;
        for (int i = 0; i < 6; i++) dg[i] = int'((w >> (4*i)) & 24'hF);
        case (pos)
            0, 2:    lim = 9;
            1, 3:    lim = 5;
            4:       lim = (dg[5] == 2) ? 3 : 9;
            default: lim = 2;
        endcase
        if (up) dg[pos] = (dg[pos] >= lim) ? 0 : dg[pos] + 1;
        else    dg[pos] = (dg[pos] == 0) ? lim : dg[pos] - 1;
        if (dg[5] == 2 && dg[4] > 3) dg[4] = 3;
        r = 24'h0;
        for (int i = 0; i < 6; i++) r = r | (24'(dg[i]) << (4*i));
        return r;
    endfunction

    function automatic logic [23:0] rand_time();
        int hh = int'($urandom_range(0, 23));
        int mm = int'($urandom_range(0, 59));
        int ss = int'($urandom_range(0, 59));
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_cycle(input bit r, input logic [5:0] b, input logic [23:0] td);
        exp_t e;
        int   prev_mode;
        if (r) begin
            m_mode = 0; m_h = 0; m_v = 0; m_cnt = 0; m_tl = 0; m_tld = 24'h0;
            for (int k = 0; k < 4; k++) begin m_al[k] = 24'h0; m_act[k] = 0; end
        end else begin
            prev_mode = m_mode;
            m_tl = 0;
            if (b[5]) begin
                if (m_mode == 0)      begin m_mode = 1; m_v = 0; end
                else if (m_mode == 1) begin m_mode = 2; m_v = 0; end
                else if (m_v < 3)     m_v = m_v + 1;
                else                  begin m_mode = 0; m_v = 0; end
                m_h = 0;
            end else if (b[4]) begin
                if (m_mode == 2) m_act[m_v] = !m_act[m_v];
            end else if (b[3] || b[2]) begin
                if (m_mode != 0) m_h = b[3] ? (m_h + 1) % 6 : (m_h + 5) % 6;
            end else if (b[1] || b[0]) begin
                if (m_mode == 1) begin
                    m_tld = model_step(td, m_h, b[1]);
                    m_tl  = 1;
                end else if (m_mode == 2) begin
                    m_al[m_v] = model_step(m_al[m_v], m_h, b[1]);
                end
            end
            if (prev_mode == 0 || b != 6'b0) m_cnt = 0;
            else if (m_cnt == T - 1) begin m_mode = 0; m_h = 0; m_v = 0; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
        end
        e.st   = mode_to_state(m_mode);
        e.h    = m_h;
        e.v    = m_v;
        e.al   = {m_al[3], m_al[2], m_al[1], m_al[0]};
        e.act  = {m_act[3], m_act[2], m_act[1], m_act[0]};
        e.hold = (m_mode == 1);
        e.tl   = m_tl;
        e.tld  = m_tld;
        sb.push_back(e);
    endtask

    task automatic step(input bit r, input logic [5:0] b, input logic [23:0] td);
        reset = r;
        {btn_mode, btn_toggle, btn_left, btn_right, btn_up, btn_down} = b;
        time_data = td;
        model_cycle(r, b, td);
        @(posedge clock);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_state", 96'(state), 96'(e.st));
                chk("sb_h_ptr", 96'(h_ptr), 96'(e.h));
                chk("sb_v_ptr", 96'(v_ptr), 96'(e.v));
                chk("sb_alarm_data", alarm_data, e.al);
                chk("sb_is_activated", 96'(is_activated), 96'(e.act));
                chk("sb_time_hold", 96'(time_hold), 96'(e.hold));
                chk("sb_time_load", 96'(time_load), 96'(e.tl));
                chk("sb_time_load_data", 96'(time_load_data), 96'(e.tld));
            end
        end
    end

    initial begin
        state_t seq_st[6];
        int     seq_v[6];
        logic [5:0] b;
        seq_st = '{time_setting_state, alarm_setting_state, alarm_setting_state,
                   alarm_setting_state, alarm_setting_state, normal_state};
        seq_v  = '{0, 0, 1, 2, 3, 0};

        step(1, B_NONE, 24'h0);
        step(1, B_NONE, 24'h0);
        chk("rst_state", 96'(state), 96'(normal_state));
        chk("rst_alarm", alarm_data, 96'h0);
        chk("rst_load", 96'({time_hold, time_load, time_load_data}), 96'h0);

        for (int i = 0; i < 6; i++) begin
            step(0, B_MODE, rand_time());
            chk("seq_state", 96'(state), 96'(seq_st[i]));
            chk("seq_v_ptr", 96'(v_ptr), 96'(seq_v[i]));
            chk("seq_h_ptr", 96'(h_ptr), 96'(0));
        end

        step(0, B_MODE, rand_time());
        step(0, B_RIGHT, rand_time());
        chk("right_wrap_h", 96'(h_ptr), 96'(5));
        step(0, B_UP, 24'h195959);
        chk("hour_clamp_load", 96'(time_load), 96'(1));
        chk("hour_clamp_data", 96'(time_load_data), 96'h235959);
        step(0, B_NONE, 24'h235959);
        chk("load_one_cycle", 96'(time_load), 96'(0));

        step(0, B_MODE, rand_time());
        step(0, B_MODE, rand_time());
        step(0, B_MODE, rand_time());
        step(0, B_LEFT, rand_time());
        step(0, B_DOWN, rand_time());
        chk("alarm2_digit1", 96'(alarm_data[55:52]), 96'(5));
        step(0, B_TOG, rand_time());
        chk("toggle_v2", 96'(is_activated), 96'(4'b0100));

        step(0, B_MODE, rand_time());
        step(0, B_MODE, rand_time());
        step(0, B_MODE, rand_time());
        step(0, B_RIGHT, rand_time());
        step(0, B_LEFT | B_UP, 24'h123456);
        chk("left_beats_up_h", 96'(h_ptr), 96'(0));
        chk("left_beats_up_load", 96'(time_load), 96'(0));

        for (int i = 0; i < 4; i++) step(0, B_MODE, rand_time());
        for (int i = 0; i < 7; i++) step(0, B_NONE, rand_time());
        chk("timeout_not_yet", 96'(state), 96'(alarm_setting_state));
        step(0, B_NONE, rand_time());
        chk("timeout_fired", 96'(state), 96'(normal_state));

        for (int i = 0; i < 5; i++) step(0, B_MODE, rand_time());
        for (int i = 0; i < 7; i++) step(0, B_NONE, rand_time());
        step(0, B_RIGHT, rand_time());
        chk("timeout_pulse_wins", 96'(state), 96'(alarm_setting_state));
        chk("timeout_pulse_v", 96'(v_ptr), 96'(3));

        step(0, B_MODE, rand_time());
        step(0, B_MODE, rand_time());
        step(1, B_UP, rand_time());
        chk("rst_mid_edit_state", 96'(state), 96'(normal_state));
        chk("rst_mid_edit_load", 96'(time_load), 96'(0));
        chk("rst_mid_edit_alarm", 96'({alarm_data, is_activated}), 96'h0);

        for (int i = 0; i < 4000; i++) begin
            b = B_NONE;
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < 6; k++) b[k] = ($urandom_range(0, 3) == 0);
            end
            step(($urandom_range(0, 499) == 0), b, rand_time());
        end

        step(0, B_NONE, rand_time());
        #10;
        chk("sb_drained", 96'(sb.size()), 96'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
